// File: rtl/mem_wb_stage.sv
// Memory-access stage and M/WB pipeline register of the pipelined MIPS core.
// Word loads and stores, sign-extended halfword loads, and halfword stores done as a two-cycle read-modify-write.
module mem_wb_stage #(
  parameter int pc_size       = 18,
  parameter int data_size     = 32,
  parameter int mem_addr_size = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     M_MemtoReg,
  input  logic                     M_RegWrite,
  input  logic                     M_MemWrite,
  input  logic                     M_Jal,
  input  logic                     M_Lh,
  input  logic                     M_Sh,
  input  logic [data_size-1:0]     M_ALU_result,
  input  logic [data_size-1:0]     M_Rt_data,
  input  logic [pc_size-1:0]       M_PCplus8,
  input  logic [4:0]               M_WR_out,
  input  logic [data_size-1:0]     DM_read_data,
  output logic [mem_addr_size-1:0] DM_addr,
  output logic                     DM_enable,
  output logic                     DM_write,
  output logic [data_size-1:0]     DM_write_data,
  output logic                     M_stall,
  output logic                     WB_RegWrite,
  output logic [4:0]               WB_WR_out,
  output logic [data_size-1:0]     WB_WD,
  output logic                     WB_misalign
);

  typedef enum logic {IDLE, SH_WR} state_t;

  state_t               state_q, state_d;
  logic [data_size-1:0] sh_word_q, sh_word_d;

  logic                 wb_regwrite_q, wb_regwrite_d;
  logic [4:0]           wb_wr_q, wb_wr_d;
  logic [data_size-1:0] wb_wd_q, wb_wd_d;
  logic                 wb_mis_q, wb_mis_d;

  logic                 is_load, is_sh, is_sw, is_lh, is_lw;
  logic                 half_sel;
  logic [15:0]          rd_half;
  logic [data_size-1:0] load_data, merge_word, wb_data;
  logic                 misalign;
  logic                 wb_bubble;

  assign DM_addr = M_ALU_result[mem_addr_size+1:2];

  // Instruction decode; store wins if both MemWrite and MemtoReg are set.
  always_comb begin
    is_load  = M_MemtoReg & ~M_MemWrite;
    is_sh    = M_MemWrite & M_Sh;
    is_sw    = M_MemWrite & ~M_Sh;
    is_lh    = is_load & M_Lh;
    is_lw    = is_load & ~M_Lh;
    half_sel = M_ALU_result[1];
  end

  // Big-endian halfword select: address bit 1 clear picks the upper half.
  always_comb begin
    rd_half    = half_sel ? DM_read_data[15:0] : DM_read_data[data_size-1 -: 16];
    load_data  = is_lh ? {{(data_size-16){rd_half[15]}}, rd_half} : DM_read_data;
    merge_word = half_sel ? {DM_read_data[data_size-1:16], M_Rt_data[15:0]}
                          : {M_Rt_data[15:0], DM_read_data[data_size-17:0]};
    misalign   = 1'b0;
    if (is_sh || is_lh)
      misalign = M_ALU_result[0];
    else if (is_sw || is_lw)
      misalign = (M_ALU_result[1:0] != 2'b00);
  end

  always_comb begin
    if (M_Jal)
      wb_data = {{(data_size-pc_size){1'b0}}, M_PCplus8};
    else if (M_MemtoReg)
      wb_data = load_data;
    else
      wb_data = M_ALU_result;
  end

  // Memory control FSM; reset low forces the strobes off combinationally.
  always_comb begin
    state_d       = state_q;
    sh_word_d     = sh_word_q;
    DM_enable     = 1'b0;
    DM_write      = 1'b0;
    DM_write_data = M_Rt_data;
    M_stall       = 1'b0;
    wb_bubble     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_sh) begin
          DM_enable = 1'b1;
          M_stall   = 1'b1;
          wb_bubble = 1'b1;
          sh_word_d = merge_word;
          state_d   = SH_WR;
        end else if (is_sw) begin
          DM_enable = 1'b1;
          DM_write  = 1'b1;
        end else if (is_load) begin
          DM_enable = 1'b1;
        end
      end
      SH_WR: begin
        DM_enable     = 1'b1;
        DM_write      = 1'b1;
        DM_write_data = sh_word_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      DM_enable = 1'b0;
      DM_write  = 1'b0;
      M_stall   = 1'b0;
    end
  end

  always_comb begin
    if (wb_bubble) begin
      wb_regwrite_d = 1'b0;
      wb_wr_d       = '0;
      wb_wd_d       = '0;
      wb_mis_d      = 1'b0;
    end else begin
      wb_regwrite_d = M_RegWrite;
      wb_wr_d       = M_WR_out;
      wb_wd_d       = wb_data;
      wb_mis_d      = misalign;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      sh_word_q     <= '0;
      wb_regwrite_q <= 1'b0;
      wb_wr_q       <= '0;
      wb_wd_q       <= '0;
      wb_mis_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_word_q     <= sh_word_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_wr_q       <= wb_wr_d;
      wb_wd_q       <= wb_wd_d;
      wb_mis_q      <= wb_mis_d;
    end
  end

  assign WB_RegWrite = wb_regwrite_q;
  assign WB_WR_out   = wb_wr_q;
  assign WB_WD       = wb_wd_q;
  assign WB_misalign = wb_mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of single-cycle instructions plus
// hand-written halfword-store and reset-in-SH_WR sequences.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal, M_Lh, M_Sh;
  logic [31:0] M_ALU_result, M_Rt_data;
  logic [17:0] M_PCplus8;
  logic [4:0]  M_WR_out;
  logic [31:0] DM_read_data;
  logic [15:0] DM_addr;
  logic        DM_enable, DM_write;
  logic [31:0] DM_write_data;
  logic        M_stall;
  logic        WB_RegWrite;
  logic [4:0]  WB_WR_out;
  logic [31:0] WB_WD;
  logic        WB_misalign;

  logic [31:0] mem [0:255];
  int unsigned tests = 0;
  int unsigned fails = 0;

  mem_wb_stage #(.pc_size(18), .data_size(32), .mem_addr_size(16)) dut (
    .clk(clk), .rst(rst),
    .M_MemtoReg(M_MemtoReg), .M_RegWrite(M_RegWrite), .M_MemWrite(M_MemWrite),
    .M_Jal(M_Jal), .M_Lh(M_Lh), .M_Sh(M_Sh),
    .M_ALU_result(M_ALU_result), .M_Rt_data(M_Rt_data), .M_PCplus8(M_PCplus8),
    .M_WR_out(M_WR_out), .DM_read_data(DM_read_data),
    .DM_addr(DM_addr), .DM_enable(DM_enable), .DM_write(DM_write),
    .DM_write_data(DM_write_data), .M_stall(M_stall),
    .WB_RegWrite(WB_RegWrite), .WB_WR_out(WB_WR_out), .WB_WD(WB_WD),
    .WB_misalign(WB_misalign)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  assign DM_read_data = mem[DM_addr[7:0]];
  always @(negedge clk) if (DM_enable && DM_write) mem[DM_addr[7:0]] <= DM_write_data;

  typedef struct {
    logic        pre;
    logic [7:0]  pidx;
    logic [31:0] pval;
    logic        mtr, rw, mw, jal, lh, sh;
    logic [31:0] alu, rt;
    logic [17:0] pc8;
    logic [4:0]  wr;
    logic [31:0] e_wd;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic        e_mis, e_en, e_dw;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic mtr, rw, mw, jal, lh, sh,
                        input logic [31:0] alu, rt, input logic [17:0] pc8, input logic [4:0] wr);
    M_MemtoReg = mtr; M_RegWrite = rw; M_MemWrite = mw;
    M_Jal = jal; M_Lh = lh; M_Sh = sh;
    M_ALU_result = alu; M_Rt_data = rt; M_PCplus8 = pc8; M_WR_out = wr;
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    //         pre pidx pval           mtr rw mw jal lh sh alu            rt             pc8      wr     e_wd           e_rw e_wr  mis en dw
    vecs[0]  = '{1, 4, 32'h12345678, 1, 1, 0, 0, 0, 0, 32'h10,       32'h0,        18'h0,   5'd8,  32'h12345678, 1, 5'd8,  0, 1, 0};
    vecs[1]  = '{1, 4, 32'h80017FFF, 1, 1, 0, 0, 1, 0, 32'h10,       32'h0,        18'h0,   5'd9,  32'hFFFF8001, 1, 5'd9,  0, 1, 0};
    vecs[2]  = '{0, 0, 32'h0,        1, 1, 0, 0, 1, 0, 32'h12,       32'h0,        18'h0,   5'd10, 32'h00007FFF, 1, 5'd10, 0, 1, 0};
    vecs[3]  = '{0, 0, 32'h0,        1, 1, 0, 0, 1, 0, 32'h11,       32'h0,        18'h0,   5'd11, 32'hFFFF8001, 1, 5'd11, 1, 1, 0};
    vecs[4]  = '{0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        18'h0,   5'd5,  32'hDEADBEEF, 1, 5'd5,  0, 0, 0};
    vecs[5]  = '{0, 0, 32'h0,        1, 1, 0, 1, 0, 0, 32'h10,       32'h0,        18'h104, 5'd31, 32'h00000104, 1, 5'd31, 0, 1, 0};
    vecs[6]  = '{0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h20,       32'hCAFEF00D, 18'h0,   5'd0,  32'h20,       0, 5'd0,  0, 1, 1};
    vecs[7]  = '{0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 32'h20,       32'h0,        18'h0,   5'd12, 32'hCAFEF00D, 1, 5'd12, 0, 1, 0};
    vecs[8]  = '{0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 32'h13,       32'h0,        18'h0,   5'd13, 32'h80017FFF, 1, 5'd13, 1, 1, 0};
    vecs[9]  = '{0, 0, 32'h0,        0, 1, 0, 0, 0, 1, 32'h44,       32'h0,        18'h0,   5'd14, 32'h44,       1, 5'd14, 0, 0, 0};
    vecs[10] = '{0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h22,       32'h01020304, 18'h0,   5'd0,  32'h22,       0, 5'd0,  1, 1, 1};
    vecs[11] = '{0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 32'h20,       32'h0,        18'h0,   5'd15, 32'h01020304, 1, 5'd15, 0, 1, 0};

    // Reset state, with a load presented so the strobes must be forced off.
    rst = 1'b0;
    set_in(1, 1, 0, 0, 0, 0, 32'h10, 32'h0, 18'h0, 5'd8);
    #2;
    chk("rst_stall", {31'd0, M_stall}, 32'd0);
    chk("rst_en", {31'd0, DM_enable}, 32'd0);
    chk("rst_dw", {31'd0, DM_write}, 32'd0);
    @(negedge clk); #1;
    chk("rst_wb_rw", {31'd0, WB_RegWrite}, 32'd0);
    chk("rst_wb_wr", {27'd0, WB_WR_out}, 32'd0);
    chk("rst_wb_wd", WB_WD, 32'd0);
    chk("rst_wb_mis", {31'd0, WB_misalign}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (vecs[i].pre) mem[vecs[i].pidx] = vecs[i].pval;
      set_in(vecs[i].mtr, vecs[i].rw, vecs[i].mw, vecs[i].jal, vecs[i].lh, vecs[i].sh,
             vecs[i].alu, vecs[i].rt, vecs[i].pc8, vecs[i].wr);
      #1;
      a = vecs[i].alu;
      chk($sformatf("v%0d_en", i), {31'd0, DM_enable}, {31'd0, vecs[i].e_en});
      chk($sformatf("v%0d_dw", i), {31'd0, DM_write}, {31'd0, vecs[i].e_dw});
      chk($sformatf("v%0d_stall", i), {31'd0, M_stall}, 32'd0);
      chk($sformatf("v%0d_addr", i), {16'd0, DM_addr}, {16'd0, a[17:2]});
      @(negedge clk); #1;
      chk($sformatf("v%0d_wd", i), WB_WD, vecs[i].e_wd);
      chk($sformatf("v%0d_wr", i), {27'd0, WB_WR_out}, {27'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_rw", i), {31'd0, WB_RegWrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_mis", i), {31'd0, WB_misalign}, {31'd0, vecs[i].e_mis});
    end

    // Halfword store RMW, then a misaligned sh back-to-back.
    @(posedge clk); #1;
    mem[2] = 32'hAAAABBBB;
    set_in(0, 0, 1, 0, 0, 1, 32'h0A, 32'h00001234, 18'h0, 5'd0);
    #1;
    chk("sh1_c1_stall", {31'd0, M_stall}, 32'd1);
    chk("sh1_c1_dw", {31'd0, DM_write}, 32'd0);
    chk("sh1_c1_en", {31'd0, DM_enable}, 32'd1);
    @(negedge clk); #1;
    chk("sh1_bubble_rw", {31'd0, WB_RegWrite}, 32'd0);
    @(posedge clk); #1;
    chk("sh1_c2_dw", {31'd0, DM_write}, 32'd1);
    chk("sh1_c2_wdata", DM_write_data, 32'hAAAA1234);
    chk("sh1_c2_stall", {31'd0, M_stall}, 32'd0);
    @(negedge clk); #1;
    chk("sh1_mem", mem[2], 32'hAAAA1234);
    chk("sh1_retire_wd", WB_WD, 32'h0000000A);
    chk("sh1_retire_mis", {31'd0, WB_misalign}, 32'd0);
    @(posedge clk); #1;
    set_in(0, 0, 1, 0, 0, 1, 32'h09, 32'h00005555, 18'h0, 5'd0);
    #1;
    chk("sh2_c1_stall", {31'd0, M_stall}, 32'd1);
    @(negedge clk); #1;
    chk("sh2_bubble_mis", {31'd0, WB_misalign}, 32'd0);
    @(posedge clk); #1;
    chk("sh2_c2_dw", {31'd0, DM_write}, 32'd1);
    chk("sh2_c2_wdata", DM_write_data, 32'h55551234);
    chk("sh2_c2_stall", {31'd0, M_stall}, 32'd0);
    @(negedge clk); #1;
    chk("sh2_mem", mem[2], 32'h55551234);
    chk("sh2_retire_mis", {31'd0, WB_misalign}, 32'd1);
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    @(negedge clk); #1;
    chk("sh2_mis_pulse", {31'd0, WB_misalign}, 32'd0);

    // Reset asserted while in SH_WR aborts the write.
    @(posedge clk); #1;
    mem[3] = 32'h11112222;
    set_in(0, 1, 1, 0, 0, 1, 32'h0C, 32'h0000BEEF, 18'h0, 5'd7);
    #1;
    chk("shr_c1_stall", {31'd0, M_stall}, 32'd1);
    @(negedge clk); #1;
    @(posedge clk); #1;
    chk("shr_c2_dw", {31'd0, DM_write}, 32'd1);
    chk("shr_c2_wdata", DM_write_data, 32'hBEEF2222);
    rst = 1'b0;
    #1;
    chk("shr_rst_dw", {31'd0, DM_write}, 32'd0);
    chk("shr_rst_en", {31'd0, DM_enable}, 32'd0);
    chk("shr_rst_stall", {31'd0, M_stall}, 32'd0);
    @(negedge clk); #1;
    chk("shr_mem", mem[3], 32'h11112222);
    chk("shr_wb_rw", {31'd0, WB_RegWrite}, 32'd0);
    chk("shr_wb_wd", WB_WD, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("shr_idle_stall", {31'd0, M_stall}, 32'd1);
    chk("shr_idle_dw", {31'd0, DM_write}, 32'd0);
    set_in(0, 1, 0, 0, 0, 0, 32'h77, 32'h0, 18'h0, 5'd3);
    @(negedge clk); #1;
    chk("post_rst_wd", WB_WD, 32'h77);
    chk("post_rst_mem", mem[3], 32'h11112222);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus M/WB pipeline register of the pipelined MIPS core. It consumes the M-stage control and data bundle, drives the word-wide data memory, and performs halfword loads with sign extension. Halfword stores are done as a two-cycle read-modify-write, with a stall to the upstream pipeline. It registers the selected write-back value, destination register and write enable for the register file.

## Interface
- pc_size, 18, width of PC+8 value
- data_size, 32, datapath width
- mem_addr_size, 16, data-memory word-address width

- clk  in  1  pipeline clock; all state updates on falling edge
- rst  in  1  asynchronous active-low reset (rst==0 resets immediately)
- M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal, M_Lh, M_Sh  in  1 each  M-stage control
- M_ALU_result  in  data_size  byte address, or ALU result for write-back
- M_Rt_data  in  data_size  store data
- M_PCplus8  in  pc_size  link value for jal
- M_WR_out  in  5  destination register
- DM_read_data  in  data_size  word read from DM_addr, combinational, same cycle
- DM_addr  out  mem_addr_size  word address = M_ALU_result[mem_addr_size+1:2]
- DM_enable  out  1  memory access this cycle
- DM_write  out  1  memory samples DM_write_data at falling edge when 1
- DM_write_data  out  data_size  word to write
- M_stall  out  1  freeze EX_M and earlier stages this cycle
- WB_RegWrite  out  1  registered write enable
- WB_WR_out  out  5  registered destination
- WB_WD  out  data_size  registered write-back data
- WB_misalign  out  1  registered one-cycle flag: misaligned access retired

## Operation
- FSM states: IDLE, SH_WR. Merge register sh_word (data_size).
- Halfword select h = M_ALU_result[1]. Big-endian: h=0 selects bits [31:16], h=1 selects bits [15:0].
- Memory op is decoded only when M_MemWrite or M_MemtoReg is set. A store with M_Sh=0 is sw. A load with M_Lh=0 is lw.
- M_Sh=1 with M_MemWrite=0 is not a memory op.
- IDLE, sw:
  - DM_enable=1, DM_write=1, DM_write_data=M_Rt_data.
- IDLE, sh:
  - DM_enable=1, DM_write=0, M_stall=1.
  - At the falling edge, sh_word <= DM_read_data with the selected halfword replaced by M_Rt_data[15:0]. State -> SH_WR.
  - The WB register loads a bubble (WB_RegWrite=0).
- SH_WR:
  - DM_enable=1, DM_write=1, DM_write_data=sh_word, M_stall=0.
  - At the falling edge, the WB register retires the sh and state -> IDLE.
  - The EX_M inputs are unchanged during this cycle because the upstream stages were frozen.
- Loads:
  - DM_enable=1, DM_write=0.
  - lh data = the selected halfword sign-extended to data_size. lw data = DM_read_data.
- Write-back select, in priority order:
  - M_Jal: zero-extended M_PCplus8.
  - M_MemtoReg: load data.
  - Otherwise: M_ALU_result.
- Misalignment:
  - Halfword op with M_ALU_result[0]=1 is misaligned.
  - Word op with M_ALU_result[1:0]!=0 is misaligned.
  - The access still proceeds with the low bits truncated.
  - WB_misalign=1 for one cycle when the instruction retires; for sh that is the SH_WR edge.
- Idle outputs: when there is no memory op, DM_enable=0 and DM_write=0. DM_addr still follows M_ALU_result.

## Timing
- Reset values (while rst==0):
  - State IDLE, sh_word=0.
  - WB_RegWrite=0, WB_WR_out=0, WB_WD=0, WB_misalign=0.
  - M_stall=0, DM_write=0, DM_enable=0, forced combinationally.
- Latency:
  - All non-sh instructions take 1 falling edge from M inputs to WB outputs.
  - sh takes 2 edges, with exactly one stall cycle.
- Back-to-back sh: the second sh enters only after SH_WR retires the first. Each sh costs one stall cycle. There is no retrigger in SH_WR.
- Reset asserted in SH_WR: the write is aborted (DM_write=0 immediately) and state returns to IDLE. Memory is unchanged.
- Reset released mid-cycle: the first state update occurs at the next falling edge.
- M_stall is combinational from the M inputs and state. The upstream logic must sample it before the same falling edge.

## Test plan
- lw: mem[4]=0x12345678, M_ALU_result=0x10, MemtoReg=1, RegWrite=1, WR=8 -> after 1 edge WB_WD=0x12345678, WB_WR_out=8, WB_RegWrite=1, M_stall never 1.
- lh sign extension: mem[4]=0x8001_7FFF.
  - Address 0x10 -> WB_WD=0xFFFF8001.
  - Address 0x12 -> WB_WD=0x00007FFF.
- sh RMW: mem[2]=0xAAAABBBB, sh Rt=0x00001234 to address 0x0A.
  - Cycle 1: M_stall=1, DM_write=0, WB_RegWrite=0.
  - Cycle 2: DM_write=1, DM_write_data=0xAAAA1234, M_stall=0.
  - Afterwards mem[2]=0xAAAA1234.
- jal priority: M_Jal=1, M_MemtoReg=1, PCplus8=0x00104, WR=31 -> WB_WD=0x00000104, WB_WR_out=31.
- Reset mid-sh: drop rst to 0 during SH_WR -> DM_write=0 immediately, memory unchanged, all WB outputs 0; after release, state is IDLE.
- Misaligned lh at address 0x11 -> WB_misalign=1 for exactly one cycle, with data taken from the h=0 halfword.
